// File: rtl/cursor_controller_if.sv
// Button inputs, pixel position and cursor outputs of the cursor controller.
// master drives buttons/hc_visible; slave (the controller) drives the rest.
interface cursor_controller_if;
  logic        btn_left;
  logic        btn_right;
  logic        btn_sel;
  logic [10:0] hc_visible;
  logic [10:0] pos_a;
  logic [10:0] pos_b;
  logic        active_sel;
  logic [10:0] delta;
  logic        in_cursor_a;
  logic        in_cursor_b;
  logic        in_vertical_line;

  modport master (
    output btn_left, btn_right, btn_sel, hc_visible,
    input  pos_a, pos_b, active_sel, delta,
    input  in_cursor_a, in_cursor_b, in_vertical_line
  );

  modport slave (
    input  btn_left, btn_right, btn_sel, hc_visible,
    output pos_a, pos_b, active_sel, delta,
    output in_cursor_a, in_cursor_b, in_vertical_line
  );
endinterface

// File: rtl/cursor_controller.sv
// Two-cursor position controller: step/auto-repeat on left/right, select
// toggle, edge and non-crossing limits. Ports: clk_fpga, rst (sync, low), bus.
module cursor_controller #(
  parameter logic [10:0] POS_A_DEFAULT = 11'd256,
  parameter logic [10:0] POS_B_DEFAULT = 11'd768,
  parameter logic [10:0] SPACE         = 11'd16,
  parameter logic [10:0] END_LEFT      = 11'd16,
  parameter logic [10:0] END_RIGHT     = 11'd1008,
  parameter int          HOLD_CYCLES   = 50_000_000,
  parameter int          REPEAT_CYCLES = 10_000_000
) (
  input logic clk_fpga,
  input logic rst,
  cursor_controller_if.slave bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_HOLD   = 2'd1;
  localparam logic [1:0] S_REPEAT = 2'd2;

  localparam logic [25:0] HOLD_LAST = 26'(HOLD_CYCLES - 1);
  localparam logic [25:0] REP_LAST  = 26'(REPEAT_CYCLES - 1);

  localparam logic [11:0] SP12   = {1'b0, SPACE};
  localparam logic [11:0] A_MIN  = {1'b0, END_LEFT} + SP12;
  localparam logic [11:0] B_MAX  = {1'b0, END_RIGHT};

  logic [1:0]  state_q, state_d;
  logic [25:0] cnt_q, cnt_d;
  logic        dir_q, dir_d;
  logic        sel_q, sel_d;
  logic        act_q, act_d;
  logic [10:0] pos_a_q, pos_a_d;
  logic [10:0] pos_b_q, pos_b_d;

  logic        dir_valid;
  logic        dir_left;
  logic        step;
  logic        step_left;
  logic [11:0] a12, b12;
  logic        gap_ok;

  assign dir_valid = bus.btn_left ^ bus.btn_right;
  assign dir_left  = bus.btn_left;
  assign a12       = {1'b0, pos_a_q};
  assign b12       = {1'b0, pos_b_q};
  // Two steps of room keep one SPACE gap after either cursor moves inward.
  assign gap_ok    = (a12 + SP12 + SP12) <= b12;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    step      = 1'b0;
    step_left = dir_q;
    unique case (state_q)
      S_IDLE: begin
        step_left = dir_left;
        if (dir_valid) begin
          step    = 1'b1;
          cnt_d   = '0;
          dir_d   = dir_left;
          state_d = S_HOLD;
        end
      end
      S_HOLD, S_REPEAT: begin
        if (!dir_valid || (dir_left != dir_q)) begin
          state_d = S_IDLE;
        end else if (cnt_q == ((state_q == S_HOLD) ? HOLD_LAST : REP_LAST)) begin
          step    = 1'b1;
          cnt_d   = '0;
          state_d = S_REPEAT;
        end else begin
          cnt_d = cnt_q + 26'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    pos_a_d = pos_a_q;
    pos_b_d = pos_b_q;
    sel_d   = bus.btn_sel;
    act_d   = act_q ^ (bus.btn_sel & ~sel_q);
    if (step) begin
      unique case ({act_q, step_left})
        2'b01: if (a12 >= A_MIN)         pos_a_d = pos_a_q - SPACE;
        2'b00: if (gap_ok)               pos_a_d = pos_a_q + SPACE;
        2'b11: if (gap_ok)               pos_b_d = pos_b_q - SPACE;
        2'b10: if (b12 + SP12 <= B_MAX)  pos_b_d = pos_b_q + SPACE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_fpga) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      sel_q   <= 1'b0;
      act_q   <= 1'b0;
      pos_a_q <= POS_A_DEFAULT;
      pos_b_q <= POS_B_DEFAULT;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      sel_q   <= sel_d;
      act_q   <= act_d;
      pos_a_q <= pos_a_d;
      pos_b_q <= pos_b_d;
    end
  end

  assign bus.pos_a            = pos_a_q;
  assign bus.pos_b            = pos_b_q;
  assign bus.active_sel       = act_q;
  assign bus.delta            = pos_b_q - pos_a_q;
  assign bus.in_cursor_a      = bus.hc_visible == pos_a_q;
  assign bus.in_cursor_b      = bus.hc_visible == pos_b_q;
  assign bus.in_vertical_line = bus.in_cursor_a | bus.in_cursor_b;

endmodule

// File: tb/tb_cursor_controller.sv
// Directed bench for cursor_controller with short hold/repeat timing.
// Inputs change 1 time unit after a rising edge; outputs are checked there.
module tb_cursor_controller;
  logic clk_fpga = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  cursor_controller_if bus ();

  cursor_controller #(
    .HOLD_CYCLES   (8),
    .REPEAT_CYCLES (4)
  ) dut (
    .clk_fpga (clk_fpga),
    .rst      (rst),
    .bus      (bus)
  );

  always #5 clk_fpga = ~clk_fpga;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_fpga);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    bus.btn_left  = 1'b0;
    bus.btn_right = 1'b0;
    bus.btn_sel   = 1'b0;
    rst = 1'b0;
    cyc(2);
    rst = 1'b1;
    cyc(1);
  endtask

  initial begin
    bus.btn_left   = 1'b0;
    bus.btn_right  = 1'b1;
    bus.btn_sel    = 1'b0;
    bus.hc_visible = 11'd0;
    rst = 1'b0;
    cyc(2);
    chk("rst_pos_a", 32'(bus.pos_a), 256);
    chk("rst_pos_b", 32'(bus.pos_b), 768);
    chk("rst_sel", 32'(bus.active_sel), 0);
    chk("rst_delta", 32'(bus.delta), 512);
    rst = 1'b1;
    cyc(1);
    chk("rst_release_step", 32'(bus.pos_a), 272);

    do_reset();
    bus.btn_right = 1'b1;
    cyc(3);
    bus.btn_right = 1'b0;
    cyc(5);
    chk("tap3", 32'(bus.pos_a), 272);

    do_reset();
    bus.btn_right = 1'b1;
    cyc(1);
    chk("hold_p1", 32'(bus.pos_a), 272);
    cyc(7);
    chk("hold_p8", 32'(bus.pos_a), 272);
    cyc(1);
    chk("hold_p9", 32'(bus.pos_a), 288);
    cyc(3);
    chk("hold_p12", 32'(bus.pos_a), 288);
    cyc(1);
    chk("hold_p13", 32'(bus.pos_a), 304);
    cyc(4);
    chk("hold_p17", 32'(bus.pos_a), 320);
    bus.btn_right = 1'b0;
    cyc(10);
    chk("hold_released", 32'(bus.pos_a), 320);

    do_reset();
    bus.btn_left = 1'b1;
    cyc(100);
    chk("limit_a_left", 32'(bus.pos_a), 16);
    bus.btn_left = 1'b0;
    cyc(2);
    bus.btn_sel = 1'b1;
    cyc(1);
    chk("sel_toggle", 32'(bus.active_sel), 1);
    bus.btn_sel = 1'b0;
    bus.btn_right = 1'b1;
    cyc(100);
    chk("limit_b_right", 32'(bus.pos_b), 1008);
    chk("limit_a_kept", 32'(bus.pos_a), 16);
    bus.btn_right = 1'b0;
    cyc(1);

    do_reset();
    bus.btn_sel = 1'b1;
    cyc(1);
    bus.btn_sel = 1'b0;
    bus.btn_left = 1'b1;
    cyc(200);
    chk("nocross_b", 32'(bus.pos_b), 272);
    chk("nocross_delta", 32'(bus.delta), 16);
    bus.btn_left = 1'b0;
    bus.btn_sel = 1'b1;
    cyc(1);
    chk("sel_back_a", 32'(bus.active_sel), 0);
    bus.btn_sel = 1'b0;
    bus.btn_right = 1'b1;
    cyc(40);
    chk("nocross_a", 32'(bus.pos_a), 256);
    bus.btn_right = 1'b0;

    do_reset();
    bus.btn_left = 1'b1;
    bus.btn_right = 1'b1;
    cyc(20);
    chk("both_a", 32'(bus.pos_a), 256);
    chk("both_b", 32'(bus.pos_b), 768);
    bus.btn_right = 1'b0;
    cyc(1);
    chk("both_release_step", 32'(bus.pos_a), 240);
    bus.btn_left = 1'b0;

    do_reset();
    bus.btn_right = 1'b1;
    cyc(14);
    chk("repeat_before_abort", 32'(bus.pos_a), 304);
    rst = 1'b0;
    cyc(1);
    chk("abort_pos_a", 32'(bus.pos_a), 256);
    chk("abort_pos_b", 32'(bus.pos_b), 768);
    bus.btn_right = 1'b0;
    cyc(1);
    rst = 1'b1;
    cyc(3);
    chk("abort_idle_hold", 32'(bus.pos_a), 256);
    bus.btn_right = 1'b1;
    cyc(1);
    chk("abort_idle_step", 32'(bus.pos_a), 272);
    bus.btn_right = 1'b0;

    do_reset();
    bus.hc_visible = 11'd256;
    #1;
    chk("hit_a", 32'(bus.in_cursor_a), 1);
    chk("hit_a_b", 32'(bus.in_cursor_b), 0);
    chk("hit_a_line", 32'(bus.in_vertical_line), 1);
    bus.hc_visible = 11'd768;
    #1;
    chk("hit_b", 32'(bus.in_cursor_b), 1);
    chk("hit_b_line", 32'(bus.in_vertical_line), 1);
    bus.hc_visible = 11'd500;
    #1;
    chk("hit_none", 32'({bus.in_cursor_a, bus.in_cursor_b,
                         bus.in_vertical_line}), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
